// File: rtl/png_pixel_packer.sv
// png_pixel_packer: absorbs an unthrottled pixel stream in a FIFO, tags line/frame position and packs
// PIX_PER_BEAT pixels per valid/ready beat. Define PNG_PACK_EOF_EN to add frame-end tagging (oeof).
module png_pixel_packer #(
    parameter int unsigned PIX_PER_BEAT = 2,
    parameter int unsigned FIFO_DEPTH   = 64,
    parameter int unsigned OUT_CH       = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             newframe,
    input  logic [1:0]                       colortype,
    input  logic [13:0]                      width,
    input  logic [31:0]                      height,
    input  logic                             ivalid,
    input  logic [7:0]                       ipixelr,
    input  logic [7:0]                       ipixelg,
    input  logic [7:0]                       ipixelb,
    input  logic [7:0]                       ipixela,
    output logic                             almost_full,
    output logic                             overflow,
    output logic                             ovalid,
    input  logic                             oready,
    output logic [PIX_PER_BEAT*OUT_CH*8-1:0] odata,
    output logic [PIX_PER_BEAT-1:0]          okeep,
    output logic                             osof,
    output logic                             oeol
`ifdef PNG_PACK_EOF_EN
    ,
    output logic                             oeof
`endif
);

    localparam int unsigned PW   = OUT_CH * 8;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(PIX_PER_BEAT + 1);
`ifdef PNG_PACK_EOF_EN
    localparam int unsigned TW   = 3;
`else
    localparam int unsigned TW   = 2;
`endif
    localparam int unsigned EW   = PW + TW;

    // Input-side position tracking
    logic [13:0]     width_q, x_q, x_d, eff_w, eff_x;
    logic [1:0]      colortype_q;
    logic            sof_pend_q, sof_pend_d, eff_sof;
    logic            overflow_q, overflow_d;
    logic            tag_eol, tag_eof, push, drop, fifo_full, fifo_empty;
    logic [31:0]     pix32;
    logic [EW-1:0]   wr_entry;
`ifdef PNG_PACK_EOF_EN
    logic [31:0]     height_q, y_q, y_d, eff_y, eff_h;
    logic            done_q, done_d, eff_done;
`endif

    // FIFO storage and pointers
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic [EW-1:0]   head;
    logic [PW-1:0]   head_data;
    logic            head_sof, head_eol, head_eof;
    logic            almost_full_q;

    // Packer state: accumulating lanes plus the registered output beat
    logic [PIX_PER_BEAT-1:0][PW-1:0] acc_q, acc_d, new_lanes, data_q, data_d;
    logic [CW-1:0]                   acc_cnt_q, acc_cnt_d, new_cnt;
    logic                            acc_sof_q, acc_sof_d;
    logic [PIX_PER_BEAT-1:0]         keep_q, keep_d;
    logic                            ovalid_q, ovalid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                            out_free, flush, pop, close;
    logic                            unused_sig;

    function automatic logic [PIX_PER_BEAT-1:0] lane_mask(input logic [CW-1:0] n);
        lane_mask = '0;
        for (int unsigned i = 0; i < PIX_PER_BEAT; i++) lane_mask[i] = (CW'(i) < n);
    endfunction

    // Tagging: a newframe in the same cycle applies to the pixel it accompanies
    always_comb begin
        eff_w      = newframe ? width : width_q;
        eff_x      = newframe ? 14'd0 : x_q;
        eff_sof    = newframe | sof_pend_q;
        tag_eol    = (eff_w == 14'd0) || (eff_x == eff_w - 14'd1);
        fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
`ifdef PNG_PACK_EOF_EN
        eff_y      = newframe ? 32'd0 : y_q;
        eff_h      = newframe ? height : height_q;
        eff_done   = newframe ? 1'b0 : done_q;
        tag_eof    = tag_eol && (eff_y == eff_h - 32'd1);
        push       = ivalid && !fifo_full && !eff_done;
`else
        tag_eof    = 1'b0;
        push       = ivalid && !fifo_full;
`endif
        drop       = ivalid && !push;
        x_d        = eff_x;
        sof_pend_d = eff_sof;
        if (push) begin
            x_d        = tag_eol ? 14'd0 : eff_x + 14'd1;
            sof_pend_d = 1'b0;
        end
`ifdef PNG_PACK_EOF_EN
        y_d    = eff_y;
        done_d = eff_done;
        if (push) begin
            if (tag_eol) y_d = eff_y + 32'd1;
            done_d = tag_eof;
        end
`endif
        overflow_d = newframe ? drop : (overflow_q | drop);
        pix32      = {ipixela, ipixelb, ipixelg, ipixelr};
`ifdef PNG_PACK_EOF_EN
        wr_entry   = {tag_eof, tag_eol, eff_sof, PW'(pix32)};
`else
        wr_entry   = {tag_eol, eff_sof, PW'(pix32)};
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_data = head[PW-1:0];
        head_sof  = head[PW];
        head_eol  = head[PW+1];
`ifdef PNG_PACK_EOF_EN
        head_eof  = head[PW+2];
`else
        head_eof  = 1'b0;
`endif
    end

    // Packing: a sof pixel meeting an open beat first flushes that beat without popping
    always_comb begin
        out_free  = !ovalid_q || oready;
        flush     = !fifo_empty && out_free && head_sof && (acc_cnt_q != '0);
        pop       = !fifo_empty && out_free && !flush;
        new_cnt   = acc_cnt_q + CW'(1);
        new_lanes = acc_q;
        for (int unsigned i = 0; i < PIX_PER_BEAT; i++) begin
            if (CW'(i) == acc_cnt_q) new_lanes[i] = head_data;
        end
        close     = pop && ((new_cnt == CW'(PIX_PER_BEAT)) || head_eol);
        count_d   = count_q + CNTW'(push) - CNTW'(pop);

        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        acc_sof_d = acc_sof_q;
        ovalid_d  = ovalid_q && !oready;
        data_d    = data_q;
        keep_d    = keep_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        eof_d     = eof_q;
        if (flush) begin
            ovalid_d  = 1'b1;
            data_d    = acc_q;
            keep_d    = lane_mask(acc_cnt_q);
            sof_d     = acc_sof_q;
            eol_d     = 1'b0;
            eof_d     = 1'b0;
            acc_d     = '0;
            acc_cnt_d = '0;
            acc_sof_d = 1'b0;
        end else if (close) begin
            ovalid_d  = 1'b1;
            data_d    = new_lanes;
            keep_d    = lane_mask(new_cnt);
            sof_d     = (acc_cnt_q == '0) ? head_sof : acc_sof_q;
            eol_d     = head_eol;
            eof_d     = head_eof;
            acc_d     = '0;
            acc_cnt_d = '0;
            acc_sof_d = 1'b0;
        end else if (pop) begin
            acc_d     = new_lanes;
            acc_cnt_d = new_cnt;
            acc_sof_d = (acc_cnt_q == '0) ? head_sof : acc_sof_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            width_q       <= '0;
            x_q           <= '0;
            colortype_q   <= '0;
            sof_pend_q    <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            acc_sof_q     <= 1'b0;
            ovalid_q      <= 1'b0;
            data_q        <= '0;
            keep_q        <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
        end else begin
            if (newframe) begin
                width_q     <= width;
                colortype_q <= colortype;
            end
            x_q           <= x_d;
            sof_pend_q    <= sof_pend_d;
            overflow_q    <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q       <= count_d;
            almost_full_q <= (count_d >= CNTW'(FIFO_DEPTH - 8));
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_sof_q     <= acc_sof_d;
            ovalid_q      <= ovalid_d;
            data_q        <= data_d;
            keep_q        <= keep_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
        end
    end

`ifdef PNG_PACK_EOF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            height_q <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            if (newframe) height_q <= height;
            y_q    <= y_d;
            done_q <= done_d;
        end
    end

    assign oeof       = eof_q;
    assign unused_sig = ^{colortype_q, eof_d};
`else
    assign unused_sig = ^{colortype_q, height, tag_eof, head_eof, eof_q};
`endif

    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign ovalid      = ovalid_q;
    assign odata       = data_q;
    assign okeep       = keep_q;
    assign osof        = sof_q;
    assign oeol        = eol_q;

endmodule

// File: tb/tb_png_pixel_packer.sv
// Directed bench for png_pixel_packer: default instance (2 lanes, RGBA, depth 64) plus an RGB single-lane instance.
module tb_png_pixel_packer;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  keep;
        logic        sof;
        logic        eol;
        logic        eof;
    } beat_t;

    logic        clk, rstn, newframe, newframe3, ivalid, ivalid3, oready;
    logic [1:0]  colortype;
    logic [13:0] width;
    logic [31:0] height;
    logic [7:0]  ipixelr, ipixelg, ipixelb, ipixela;
    logic        almost_full, overflow, ovalid, osof, oeol, oeof;
    logic [63:0] odata;
    logic [1:0]  okeep;
    logic        almost_full3, overflow3, ovalid3, osof3, oeol3, oeof3;
    logic [23:0] odata3;
    logic [0:0]  okeep3;

    int checks = 0;
    int errors = 0;
    beat_t beats[$];

    png_pixel_packer dut (
        .clk(clk), .rstn(rstn), .newframe(newframe), .colortype(colortype), .width(width),
        .height(height), .ivalid(ivalid), .ipixelr(ipixelr), .ipixelg(ipixelg),
        .ipixelb(ipixelb), .ipixela(ipixela), .almost_full(almost_full), .overflow(overflow),
        .ovalid(ovalid), .oready(oready), .odata(odata), .okeep(okeep), .osof(osof), .oeol(oeol)
`ifdef PNG_PACK_EOF_EN
        , .oeof(oeof)
`endif
    );

    png_pixel_packer #(.PIX_PER_BEAT(1), .FIFO_DEPTH(16), .OUT_CH(3)) dut3 (
        .clk(clk), .rstn(rstn), .newframe(newframe3), .colortype(colortype), .width(width),
        .height(height), .ivalid(ivalid3), .ipixelr(ipixelr), .ipixelg(ipixelg),
        .ipixelb(ipixelb), .ipixela(ipixela), .almost_full(almost_full3), .overflow(overflow3),
        .ovalid(ovalid3), .oready(oready), .odata(odata3), .okeep(okeep3), .osof(osof3), .oeol(oeol3)
`ifdef PNG_PACK_EOF_EN
        , .oeof(oeof3)
`endif
    );

`ifndef PNG_PACK_EOF_EN
    assign oeof  = 1'b0;
    assign oeof3 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ovalid && oready) beats.push_back({odata, okeep, osof, oeol, oeof});
    end

    function automatic logic [31:0] px(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b + 8'hC0, b + 8'h80, b + 8'h40, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ivalid = 1'b0;
        newframe = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_px(input int k);
        logic [31:0] p;
        p = px(k);
        {ipixela, ipixelb, ipixelg, ipixelr} = p;
        ivalid = 1'b1;
    endtask

    task automatic start_frame(input logic [13:0] w, input logic [31:0] h);
        width = w;
        height = h;
        newframe = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input int i, input logic [63:0] d, input logic [1:0] kp,
                              input logic s, input logic e, input logic f);
        if (i < beats.size()) begin
            check($sformatf("beat%0d.data", i), beats[i].data, d);
            check($sformatf("beat%0d.keep", i), 64'(beats[i].keep), 64'(kp));
            check($sformatf("beat%0d.sof", i), 64'(beats[i].sof), 64'(s));
            check($sformatf("beat%0d.eol", i), 64'(beats[i].eol), 64'(e));
            check($sformatf("beat%0d.eof", i), 64'(beats[i].eof), 64'(f));
        end
    endtask

    initial begin
        rstn = 1'b0; newframe = 1'b0; newframe3 = 1'b0; ivalid = 1'b0; ivalid3 = 1'b0;
        oready = 1'b0; colortype = 2'd2; width = '0; height = '0;
        {ipixela, ipixelb, ipixelg, ipixelr} = '0;
        idle(3);
        check("rst.ovalid", 64'(ovalid), 64'(0));
        check("rst.odata", odata, 64'(0));
        check("rst.okeep", 64'(okeep), 64'(0));
        check("rst.sof_eol", 64'({osof, oeol, oeof}), 64'(0));
        check("rst.flags", 64'({almost_full, overflow}), 64'(0));
        rstn = 1'b1;
        oready = 1'b1;
        idle(2);

        // w=4 h=2, eight pixels: four full beats
        start_frame(14'd4, 32'd2);
        tick();
        newframe = 1'b0;
        for (int k = 0; k < 8; k++) begin drive_px(k); tick(); end
        idle(8);
        check("t1.count", 64'(beats.size()), 64'(4));
        for (int b = 0; b < 4; b++)
            check_beat(b, {px(2*b+1), px(2*b)}, 2'b11, b == 0, b % 2 == 1, 1'b0);
        beats.delete();

        // w=3: each line is a full beat then a one-lane eol beat
        start_frame(14'd3, 32'd2);
        tick();
        newframe = 1'b0;
        for (int k = 10; k < 16; k++) begin drive_px(k); tick(); end
        idle(8);
        check("t2.count", 64'(beats.size()), 64'(4));
        check_beat(0, {px(11), px(10)}, 2'b11, 1'b1, 1'b0, 1'b0);
        check_beat(1, {32'h0, px(12)}, 2'b01, 1'b0, 1'b1, 1'b0);
        check_beat(2, {px(14), px(13)}, 2'b11, 1'b0, 1'b0, 1'b0);
        check_beat(3, {32'h0, px(15)}, 2'b01, 1'b0, 1'b1, 1'b0);
        beats.delete();

        // two-cycle latency on an idle pipe when the pixel closes the beat
        start_frame(14'd1, 32'd1);
        tick();
        newframe = 1'b0;
        drive_px(20);
        tick();
        ivalid = 1'b0;
        check("lat.n1", 64'(ovalid), 64'(0));
        tick();
        check("lat.n2.valid", 64'(ovalid), 64'(1));
        check("lat.n2.data", odata, {32'h0, px(20)});
        check("lat.n2.tags", 64'({okeep, osof, oeol}), 64'({2'b01, 1'b1, 1'b1}));
        idle(4);
        beats.delete();

        // stall: first beat held in the output register, FIFO takes pixels 2..65, pixel 66 dropped
        oready = 1'b0;
        start_frame(14'd1000, 32'd10);
        for (int k = 0; k < 70; k++) begin
            drive_px(k);
            tick();
            newframe = 1'b0;
            if (k >= 3) begin
                check("t3.hold.valid", 64'(ovalid), 64'(1));
                check("t3.hold.data", odata, {px(1), px(0)});
            end
            if (k == 56) check("t3.af_below", 64'(almost_full), 64'(0));
            if (k == 57) check("t3.af_at56", 64'(almost_full), 64'(1));
            if (k == 65) check("t3.ovf_full", 64'(overflow), 64'(0));
            if (k == 66) check("t3.ovf_drop", 64'(overflow), 64'(1));
        end
        idle(3);
        oready = 1'b1;
        idle(80);
        check("t3.count", 64'(beats.size()), 64'(33));
        for (int b = 0; b < 33; b++)
            check_beat(b, {px(2*b+1), px(2*b)}, 2'b11, b == 0, 1'b0, 1'b0);
        check("t3.ovf_sticky", 64'(overflow), 64'(1));
        check("t3.af_drained", 64'(almost_full), 64'(0));
        beats.delete();

        // newframe mid-line closes the open beat and clears overflow
        start_frame(14'd4, 32'd2);
        tick();
        newframe = 1'b0;
        check("t4.ovf_clr", 64'(overflow), 64'(0));
        for (int k = 100; k < 103; k++) begin drive_px(k); tick(); end
        ivalid = 1'b0;
        start_frame(14'd4, 32'd2);
        tick();
        newframe = 1'b0;
        for (int k = 110; k < 112; k++) begin drive_px(k); tick(); end
        idle(8);
        check("t4.count", 64'(beats.size()), 64'(3));
        check_beat(0, {px(101), px(100)}, 2'b11, 1'b1, 1'b0, 1'b0);
        check_beat(1, {32'h0, px(102)}, 2'b01, 1'b0, 1'b0, 1'b0);
        check_beat(2, {px(111), px(110)}, 2'b11, 1'b1, 1'b0, 1'b0);
        beats.delete();

        // RGB single-lane instance drops alpha
        width = 14'd1;
        height = 32'd1;
        newframe3 = 1'b1;
        {ipixela, ipixelb, ipixelg, ipixelr} = 32'h44332211;
        ivalid3 = 1'b1;
        tick();
        newframe3 = 1'b0;
        ivalid3 = 1'b0;
        check("t5.n1", 64'(ovalid3), 64'(0));
        tick();
        check("t5.valid", 64'(ovalid3), 64'(1));
        check("t5.data", 64'(odata3), 64'h332211);
        check("t5.tags", 64'({okeep3, osof3, oeol3}), 64'(3'b111));
        check("t5.flags", 64'({almost_full3, overflow3}), 64'(0));
        idle(4);
        beats.delete();

        // reset while a beat is pending and a pixel sits in the accumulator
        oready = 1'b0;
        start_frame(14'd1000, 32'd10);
        for (int k = 40; k < 43; k++) begin drive_px(k); tick(); newframe = 1'b0; end
        idle(2);
        check("rstmid.pre", 64'(ovalid), 64'(1));
        rstn = 1'b0;
        tick();
        check("rstmid.valid", 64'(ovalid), 64'(0));
        check("rstmid.data", odata, 64'(0));
        rstn = 1'b1;
        oready = 1'b1;
        idle(10);
        check("rstmid.nostale", 64'(beats.size()), 64'(0));
        start_frame(14'd2, 32'd1);
        drive_px(50);
        tick();
        newframe = 1'b0;
        drive_px(51);
        tick();
        idle(6);
        check("rstmid.count", 64'(beats.size()), 64'(1));
        check_beat(0, {px(51), px(50)}, 2'b11, 1'b1, 1'b1, 1'b0);
        beats.delete();

`ifdef PNG_PACK_EOF_EN
        // w=2 h=2: second beat carries eof, fifth pixel dropped
        start_frame(14'd2, 32'd2);
        tick();
        newframe = 1'b0;
        for (int k = 60; k < 65; k++) begin drive_px(k); tick(); end
        idle(8);
        check("t6.count", 64'(beats.size()), 64'(2));
        check_beat(0, {px(61), px(60)}, 2'b11, 1'b1, 1'b1, 1'b0);
        check_beat(1, {px(63), px(62)}, 2'b11, 1'b0, 1'b1, 1'b1);
        check("t6.ovf", 64'(overflow), 64'(1));
        beats.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
